// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the Avalon-MM memory responder:
// FSM state encoding, stall LFSR taps and byte-lane mask expansion.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCEPT = 2'd2
    } resp_state_t;

    // Right-shifting Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1 (bits 0, 2, 3, 5).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/stall_lfsr.sv
// 16-bit Fibonacci LFSR that steps only when asked; its low bits pick the
// per-transfer stall count in random-stall mode.
module stall_lfsr
    import mem_resp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= seed;
        end else if (advance) begin
            value <= {^(value & LFSR_TAPS), value[15:1]};
        end
    end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave memory with a fixed or pseudo-random number of waitrequest
// stall cycles per transfer, a side-band preload port and sticky error flags.
module avalon_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          MEM_WORDS    = 256,
    parameter int          STALL_CYCLES = 1,
    parameter bit          RANDOM_STALL = 1'b0,
    parameter int          MAX_STALL    = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  address,
    input  logic                         read,
    input  logic                         write,
    input  logic [31:0]                  writedata,
    input  logic [3:0]                   byteenable,
    output logic                         waitrequest,
    output logic [31:0]                  readdata,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    output logic                         proto_err,
    output logic                         misalign_err,
    output resp_state_t                  fsm_state
);

    localparam int AW   = $clog2(MEM_WORDS);
    localparam int CMAX = (STALL_CYCLES > MAX_STALL) ? STALL_CYCLES : MAX_STALL;
    localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

    resp_state_t   state, state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] stall_n;
    logic [31:0]   lat_addr, lat_wdata;
    logic [3:0]    lat_be;
    logic          lat_rd, lat_wr;
    logic [15:0]   lfsr;
    logic          lfsr_unused;
    logic          req, take_req, field_changed, bus_we;
    logic [AW-1:0] lat_idx;
    logic [31:0]   wmask;
    logic [31:0]   mem [MEM_WORDS];

    // Handshake: the master holds read/write and all request fields until it
    // sees waitrequest low; that single low cycle is the only accept cycle.
    assign req           = read | write;
    assign take_req      = (state == IDLE) && req;
    assign lat_idx       = lat_addr[AW+1:2];
    assign field_changed = (address != lat_addr) || (writedata != lat_wdata) ||
                           (byteenable != lat_be);
    assign bus_we        = (state == ACCEPT) && lat_wr && !reset;
    assign wmask         = lane_mask(lat_be);
    assign waitrequest   = (state != ACCEPT);
    assign fsm_state     = state;
    assign lfsr_unused   = ^lfsr[15:2];

    stall_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .seed   (LFSR_SEED),
        .advance(take_req),
        .value  (lfsr)
    );

    always_comb begin
        stall_n = CW'(STALL_CYCLES);
        if (RANDOM_STALL) begin
            stall_n = CW'(32'(lfsr[1:0]) % (MAX_STALL + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A preload strobe freezes both the stall countdown and the move to ACCEPT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = WAIT;
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (!load_en && cnt == '0) begin
                    state_next = ACCEPT;
                end
            end
            ACCEPT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read with write in the same request is serviced as a read only.
    always_ff @(posedge clk) begin
        if (take_req) begin
            lat_addr  <= address;
            lat_wdata <= writedata;
            lat_be    <= byteenable;
            lat_rd    <= read;
            lat_wr    <= write & ~read;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            readdata     <= '0;
            proto_err    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (take_req) begin
                cnt <= stall_n;
                if (read && write) proto_err <= 1'b1;
            end
            if (state == WAIT && req) begin
                if (field_changed) proto_err <= 1'b1;
                if (!load_en) begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (lat_rd) begin
                        readdata <= mem[lat_idx];
                    end
                end
            end
            if (state == ACCEPT && lat_addr[1:0] != 2'b00) misalign_err <= 1'b1;
        end
    end

    // Preload beats a bus write to the same word in the same cycle.
    always_ff @(posedge clk) begin
        if (bus_we && !(load_en && load_addr == lat_idx)) begin
            mem[lat_idx] <= (mem[lat_idx] & ~wmask) | (lat_wdata & wmask);
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule
